// File: rtl/reg_write_scoreboard.sv
// Pending-write scoreboard between ID and WB: one counter per architectural register,
// in-flight total, sticky underflow flag, and the issue freeze toward IF/ID.
module reg_write_scoreboard #(
  parameter int REG_ADDR_W = 4,
  parameter int CNT_W      = 2,
  parameter int TOT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic                  issue_wb_en,
  input  logic [REG_ADDR_W-1:0] issue_dest,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  has_two_src,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_dest,
  input  logic                  squash_valid,
  input  logic [REG_ADDR_W-1:0] squash_dest,
  output logic                  hazard_detected,
  output logic                  issue_ready,
  output logic                  freeze,
  output logic [TOT_W-1:0]      inflight,
  output logic                  underflow_err
);

  localparam int NREG    = 2**REG_ADDR_W;
  localparam int CNT_MAX = 2**CNT_W - 1;
  localparam int TOT_MAX = 2**TOT_W - 1;
  localparam int SUM_RAW = $clog2(NREG * CNT_MAX + 1);
  // The exact total is kept internally so the exposed count saturates instead of wrapping.
  localparam int SUM_W   = (SUM_RAW > TOT_W) ? SUM_RAW : TOT_W;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [TOT_W-1:0] inflight_q, inflight_d;
  logic             underflow_q, underflow_d;

  logic             accept, inc, dec_wb, dec_sq, sq_same, uf_event;
  logic [CNT_W-1:0] sq_avail;

  always_comb begin
    hazard_detected = (cnt_q[src1] != '0) | (has_two_src & (cnt_q[src2] != '0));
    issue_ready     = ~issue_wb_en | (cnt_q[issue_dest] != CNT_W'(CNT_MAX));
    freeze          = issue_valid & (hazard_detected | ~issue_ready);
  end

  // WB claims a counter first; the squash only decrements what WB left behind.
  always_comb begin
    accept   = issue_valid & ~freeze;
    inc      = accept & issue_wb_en;
    dec_wb   = wb_valid & (cnt_q[wb_dest] != '0);
    sq_same  = dec_wb & (squash_dest == wb_dest);
    sq_avail = cnt_q[squash_dest] - CNT_W'(sq_same);
    dec_sq   = squash_valid & (sq_avail != '0);
    uf_event = (wb_valid & ~dec_wb) | (squash_valid & ~dec_sq);
  end

  // NOTE: every combinational output is assigned on every path (no default-less branches), so no latches.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r]
               + CNT_W'(inc    && (issue_dest  == REG_ADDR_W'(r)))
               - CNT_W'(dec_wb && (wb_dest     == REG_ADDR_W'(r)))
               - CNT_W'(dec_sq && (squash_dest == REG_ADDR_W'(r)));
    end
    sum_d       = sum_q + SUM_W'(inc) - SUM_W'(dec_wb) - SUM_W'(dec_sq);
    inflight_d  = (sum_d > SUM_W'(TOT_MAX)) ? TOT_W'(TOT_MAX) : sum_d[TOT_W-1:0];
    underflow_d = underflow_q | uf_event;
  end

  // NOTE: state updates use non-blocking assignments so all registers sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the counter array must be reset; a stale count would be a phantom hazard after reset.
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      sum_q       <= '0;
      inflight_q  <= '0;
      underflow_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      sum_q       <= sum_d;
      inflight_q  <= inflight_d;
      underflow_q <= underflow_d;
    end
  end

  assign inflight      = inflight_q;
  assign underflow_err = underflow_q;

endmodule

// File: tb/tb_reg_write_scoreboard.sv
// Directed bench for reg_write_scoreboard: a stimulus table with hand-computed results,
// plus sequences for reset, underflow stickiness and in-flight saturation.
module tb_reg_write_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_wb_en, has_two_src, wb_valid, squash_valid;
  logic [3:0] issue_dest, src1, src2, wb_dest, squash_dest;
  logic       hazard_detected, issue_ready, freeze, underflow_err;
  logic [4:0] inflight;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg_write_scoreboard #(.REG_ADDR_W(4), .CNT_W(2), .TOT_W(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_wb_en(issue_wb_en), .issue_dest(issue_dest),
    .src1(src1), .src2(src2), .has_two_src(has_two_src),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .squash_valid(squash_valid), .squash_dest(squash_dest),
    .hazard_detected(hazard_detected), .issue_ready(issue_ready), .freeze(freeze),
    .inflight(inflight), .underflow_err(underflow_err)
  );

  typedef struct {
    logic       iv, we;
    logic [3:0] dest, s1, s2;
    logic       two, wv;
    logic [3:0] wd;
    logic       sv;
    logic [3:0] sd;
    logic       e_haz, e_rdy, e_frz;
    int         e_inf;
    logic       e_uf;
  } vec_t;

  function automatic vec_t mk(input logic iv, we, input logic [3:0] dest, s1, s2,
                              input logic two, wv, input logic [3:0] wd,
                              input logic sv, input logic [3:0] sd,
                              input logic haz, rdy, frz, input int inf, input logic uf);
    vec_t v;
    v.iv = iv; v.we = we; v.dest = dest; v.s1 = s1; v.s2 = s2; v.two = two;
    v.wv = wv; v.wd = wd; v.sv = sv; v.sd = sd;
    v.e_haz = haz; v.e_rdy = rdy; v.e_frz = frz; v.e_inf = inf; v.e_uf = uf;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    issue_valid = v.iv; issue_wb_en = v.we; issue_dest = v.dest;
    src1 = v.s1; src2 = v.s2; has_two_src = v.two;
    wb_valid = v.wv; wb_dest = v.wd; squash_valid = v.sv; squash_dest = v.sd;
  endtask

  // Combinational outputs are checked mid-cycle, registered ones just after the edge.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge clk);
    apply(v);
    #1;
    check({tag, " hazard"}, int'(hazard_detected), int'(v.e_haz));
    check({tag, " ready"},  int'(issue_ready),     int'(v.e_rdy));
    check({tag, " freeze"}, int'(freeze),          int'(v.e_frz));
    @(posedge clk);
    #1;
    check({tag, " inflight"},  int'(inflight),      v.e_inf);
    check({tag, " underflow"}, int'(underflow_err), int'(v.e_uf));
  endtask

  function automatic vec_t idle();
    return mk(0,0,0,0,0,0, 0,0,0,0, 0,1,0, 0,0);
  endfunction

  vec_t vecs [28];
  vec_t v;
  int   sum;

  initial begin
    vecs[0]  = mk(1,1, 2,0,0,0, 0, 0,0, 0, 0,1,0, 1,0);
    vecs[1]  = mk(1,1, 3,2,0,0, 0, 0,0, 0, 1,1,1, 1,0);
    vecs[2]  = mk(1,1, 3,2,0,0, 1, 2,0, 0, 1,1,1, 0,0);
    vecs[3]  = mk(1,1, 3,2,0,0, 0, 0,0, 0, 0,1,0, 1,0);
    vecs[4]  = mk(1,1, 5,0,0,0, 0, 0,0, 0, 0,1,0, 2,0);
    vecs[5]  = mk(1,0, 0,0,5,0, 0, 0,0, 0, 0,1,0, 2,0);
    vecs[6]  = mk(1,0, 0,0,5,1, 0, 0,0, 0, 1,1,1, 2,0);
    vecs[7]  = mk(0,0, 0,5,0,0, 0, 0,0, 0, 1,1,0, 2,0);
    vecs[8]  = mk(1,1, 7,0,0,0, 0, 0,0, 0, 0,1,0, 3,0);
    vecs[9]  = mk(1,1, 7,0,0,0, 0, 0,0, 0, 0,1,0, 4,0);
    vecs[10] = mk(1,1, 7,0,0,0, 0, 0,0, 0, 0,1,0, 5,0);
    vecs[11] = mk(1,1, 7,0,0,0, 0, 0,0, 0, 0,0,1, 5,0);
    vecs[12] = mk(1,0, 7,0,0,0, 0, 0,0, 0, 0,1,0, 5,0);
    vecs[13] = mk(1,1, 7,0,0,0, 1, 7,0, 0, 0,0,1, 4,0);
    vecs[14] = mk(1,1, 7,0,0,0, 0, 0,0, 0, 0,1,0, 5,0);
    vecs[15] = mk(1,1, 4,0,0,0, 0, 0,0, 0, 0,1,0, 6,0);
    vecs[16] = mk(1,1, 4,0,0,0, 1, 4,0, 0, 0,1,0, 6,0);
    vecs[17] = mk(0,0, 0,0,0,0, 1, 4,0, 0, 0,1,0, 5,0);
    vecs[18] = mk(1,1, 9,0,0,0, 0, 0,0, 0, 0,1,0, 6,0);
    vecs[19] = mk(0,0, 0,0,0,0, 0, 0,1, 9, 0,1,0, 5,0);
    vecs[20] = mk(1,1,10,0,0,0, 0, 0,0, 0, 0,1,0, 6,0);
    vecs[21] = mk(1,1,10,0,0,0, 0, 0,0, 0, 0,1,0, 7,0);
    vecs[22] = mk(0,0, 0,0,0,0, 1,10,1,10, 0,1,0, 5,0);
    vecs[23] = mk(1,1,10,0,0,0, 0, 0,0, 0, 0,1,0, 6,0);
    vecs[24] = mk(0,0, 0,0,0,0, 1,10,1,10, 0,1,0, 5,1);
    vecs[25] = mk(0,0, 0,0,0,0, 0, 0,0, 0, 0,1,0, 5,1);
    vecs[26] = mk(1,1,15,0,0,0, 0, 0,0, 0, 0,1,0, 6,1);
    vecs[27] = mk(1,0, 0,15,0,0,0, 0,0, 0, 1,1,1, 6,1);

    // Reset held two cycles while WB tries to retire r3.
    apply(idle());
    rst = 1'b1; wb_valid = 1'b1; wb_dest = 4'd3;
    repeat (2) @(posedge clk);
    #1;
    check("reset inflight",  int'(inflight),      0);
    check("reset underflow", int'(underflow_err), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(idle());
    issue_wb_en = 1'b1; issue_dest = 4'd3;
    #1;
    check("reset ready",  int'(issue_ready),     1);
    check("reset freeze", int'(freeze),          0);
    check("reset hazard", int'(hazard_detected), 0);

    for (int i = 0; i < 28; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-operation with issue, WB and squash all active.
    @(negedge clk);
    apply(mk(1,1,1,0,0,0, 1,7,1,3, 0,0,0, 0,0));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst inflight",  int'(inflight),      0);
    check("midrst underflow", int'(underflow_err), 0);
    @(negedge clk);
    rst = 1'b0;
    apply(mk(1,0,0,15,7,1, 0,0,0,0, 0,0,0, 0,0));
    #1;
    check("midrst hazard", int'(hazard_detected), 0);

    // Squash retires r9, then a WB to the now-empty r9 underflows and sticks.
    run_vec(mk(1,1,9,0,0,0, 0,0,0,0, 0,1,0, 1,0), "uf issue");
    run_vec(mk(0,0,0,9,0,0, 0,0,1,9, 1,1,0, 0,0), "uf squash");
    run_vec(mk(0,0,0,9,0,0, 1,9,0,0, 0,1,0, 0,1), "uf wb");
    for (int i = 0; i < 3; i++) run_vec(mk(0,0,0,0,0,0, 0,0,0,0, 0,1,0, 0,1), $sformatf("uf hold%0d", i));

    @(negedge clk);
    apply(idle());
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("uf cleared", int'(underflow_err), 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill r0..r14 to saturation (45 pending) and watch the total clamp at 31.
    sum = 0;
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < 3; k++) begin
        sum++;
        v = mk(1,1,4'(r),15,0,0, 0,0,0,0, 0,1,0, (sum > 31) ? 31 : sum, 0);
        run_vec(v, $sformatf("fill r%0d.%0d", r, k));
      end
    end
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 3; k++) begin
        sum--;
        v = mk(0,0,0,15,0,0, 1,4'(r),0,0, 0,1,0, (sum > 31) ? 31 : sum, 0);
        run_vec(v, $sformatf("drain r%0d.%0d", r, k));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_write_scoreboard.md
Name: reg_write_scoreboard

Overview:
- Producer-side counterpart of the ID-stage hazard check.
- Tracks register writes that have issued but not yet written back, using one pending-write counter per architectural register.
- Sits between ID and WB. ID issues instructions into it; WB and the flush path retire them.
- Raises a freeze toward IF/ID when an issuing instruction reads a register with a write in flight, or when a destination counter would overflow.

Parameters:
- REG_ADDR_W, 4, register address width; number of registers = 2**REG_ADDR_W.
- CNT_W, 2, width of each pending-write counter; max in flight per register = 2**CNT_W-1.
- TOT_W, 5, width of the total in-flight counter output.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- issue_valid  in  1  ID presents an instruction this cycle.
- issue_wb_en  in  1  issuing instruction writes a register.
- issue_dest  in  REG_ADDR_W  destination of issuing instruction.
- src1  in  REG_ADDR_W  first source of issuing instruction.
- src2  in  REG_ADDR_W  second source of issuing instruction.
- has_two_src  in  1  src2 is valid.
- wb_valid  in  1  WB stage writing a register this cycle.
- wb_dest  in  REG_ADDR_W  register being written back.
- squash_valid  in  1  an issued write was killed (branch flush) before WB.
- squash_dest  in  REG_ADDR_W  destination of the squashed write.
- hazard_detected  out  1  combinational; a source has a pending write.
- issue_ready  out  1  combinational; issue_dest counter not saturated, or issue_wb_en=0.
- freeze  out  1  combinational; issue_valid & (hazard_detected | ~issue_ready).
- inflight  out  TOT_W  registered total of all pending-write counters.
- underflow_err  out  1  registered, sticky; a retire or squash hit a zero counter.

Behaviour:
- State: cnt[r] for each register r, inflight, underflow_err. rst clears all to 0. All outputs are therefore 0 after reset, except issue_ready=1.
- hazard_detected = (cnt[src1]!=0) | (has_two_src & cnt[src2]!=0). Counter state only: no same-cycle bypass from wb_valid, so a write retiring this cycle still flags.
- issue_ready = ~issue_wb_en | (cnt[issue_dest] != 2**CNT_W-1).
- accept = issue_valid & ~freeze. An instruction is accepted only when its freeze is low; ID holds inputs stable while freeze=1.
- inc = accept & issue_wb_en. Increments cnt[issue_dest] by 1.
- dec_wb = wb_valid & cnt[wb_dest]!=0. Decrements cnt[wb_dest] by 1.
- dec_sq = squash_valid & cnt[squash_dest]!=0. Decrements cnt[squash_dest] by 1.
- Simultaneous events: per-register net delta = inc - dec_wb - dec_sq, all applied in the same cycle.
  - Issue and retire to the same register: count unchanged.
  - wb_dest == squash_dest with cnt=1: only one decrement applies (WB has priority); the squash counts as underflow.
- Underflow: wb_valid or squash_valid to a register whose cnt is 0 (after the priority rule above) leaves cnt unchanged and sets underflow_err=1 on the next edge. It stays 1 until rst.
- Overflow cannot occur: saturation is blocked by issue_ready. A decrement to the same register in the same cycle does not release issue_ready; that is pessimistic by design.
- inflight = previous value + inc - decrements actually applied. Always equals the sum of cnt[]. Never wraps at defaults (max 16*3=48 requires TOT_W>=6; TOT_W=5 saturates at 31, and the sum is not exposed beyond that).
- Latency: hazard_detected, issue_ready and freeze respond in the same cycle to issue inputs. Counter changes are visible one cycle after the edge.
- rst asserted mid-operation clears every counter at that edge regardless of issue_valid, wb_valid or squash_valid in the same cycle.
- Register 15 (PC) is tracked like any other register; no special case.

Test Plan:
- Reset: assert rst 2 cycles with wb_valid=1, wb_dest=3 -> inflight=0, underflow_err=0, issue_ready=1, freeze=0.
- RAW stall: issue dest=2 (wb_en=1); next cycle issue src1=2 -> hazard_detected=1, freeze=1. Assert wb_valid, wb_dest=2 -> still frozen that cycle; next cycle freeze=0 and the instruction is accepted.
- Second-source gating: cnt[5]=1, issue src1=0, src2=5, has_two_src=0 -> hazard_detected=0. Set has_two_src=1 -> hazard_detected=1.
- Saturation: issue 3 writes to r7 with no retire -> cnt[7]=3, inflight=3. Fourth issue to r7 -> issue_ready=0, freeze=1, inflight stays 3.
- Simultaneous: cnt[4]=1; same cycle accepted issue dest=4 plus wb_valid dest=4 -> cnt[4]=1, inflight unchanged.
- Squash/underflow: cnt[9]=1; squash_valid dest=9 -> cnt[9]=0. Then wb_valid dest=9 -> cnt[9] stays 0 and underflow_err=1 until rst.
